// File: rtl/video_timing.sv
`timescale 1ns/1ps
// video_timing: raster timing source for the +3 video path.
// Free-running pixel counters plus registered blank/sync/paper/line/frame flags, all
// advancing only on the pixel clock enable. The Z80 frame interrupt generator is built
// only when VIDEO_TIMING_IRQ_EN is defined; otherwise irq_n_o is tied high.
module video_timing #(
  parameter int unsigned HCW     = 9,
  parameter int unsigned VCW     = 9,
  parameter int unsigned HTOTAL  = 456,
  parameter int unsigned VTOTAL  = 311,
  parameter int unsigned PAPER_W = 256,
  parameter int unsigned PAPER_H = 192,
  parameter int unsigned HBB     = 320,
  parameter int unsigned HBE     = 416,
  parameter int unsigned HSB     = 344,
  parameter int unsigned HSE     = 376,
  parameter int unsigned VBB     = 248,
  parameter int unsigned VBE     = 256,
  parameter int unsigned VSB     = 248,
  parameter int unsigned VSE     = 252,
  parameter int unsigned INT_V   = 248,
  parameter int unsigned INT_H   = 0,
  parameter int unsigned INT_LEN = 64
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           ce_i,
  output logic [HCW-1:0] hcount_o,
  output logic [VCW-1:0] vcount_o,
  output logic [1:0]     blank_o,
  output logic [1:0]     sync_o,
  output logic           paper_o,
  output logic           line_o,
  output logic           frame_o,
  output logic           irq_n_o
);

  // A window edge at or beyond this limit can never be reached by the counter.
  localparam int unsigned HLim = (HTOTAL < (32'd1 << HCW)) ? HTOTAL : (32'd1 << HCW);
  localparam int unsigned VLim = (VTOTAL < (32'd1 << VCW)) ? VTOTAL : (32'd1 << VCW);

  // Half-open window [b, e), wrapping through zero when b > e; empty when b == e.
  function automatic logic in_window(input int unsigned c, input int unsigned b,
                                     input int unsigned e, input int unsigned lim);
    logic act;
    if (b >= lim || e >= lim) begin
      act = 1'b0;
    end else if (b < e) begin
      act = (c >= b) && (c < e);
    end else if (b > e) begin
      act = (c >= b) || (c < e);
    end else begin
      act = 1'b0;
    end
    return act;
  endfunction

  logic [HCW-1:0] hcount_q, hcount_d;
  logic [VCW-1:0] vcount_q, vcount_d;
  logic [1:0]     blank_q, blank_d;
  logic [1:0]     sync_q, sync_d;
  logic           paper_q, paper_d;
  logic           line_q, line_d;
  logic           frame_q, frame_d;
  int unsigned    hpos, vpos;
  logic           h_wrap, v_wrap;

  assign hpos   = 32'(hcount_q);
  assign vpos   = 32'(vcount_q);
  assign h_wrap = (hpos == HTOTAL - 1);
  assign v_wrap = (vpos == VTOTAL - 1);

  // Next counter position; holds whenever ce is low.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (ce_i) begin
      if (h_wrap) begin
        hcount_d = '0;
        vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  // Decode flags from the current (pre-increment) position; they are registered below so
  // they trail the counters by one ce.
  always_comb begin
    blank_d = {in_window(vpos, VBB, VBE, VLim), in_window(hpos, HBB, HBE, HLim)};
    sync_d  = {in_window(vpos, VSB, VSE, VLim), in_window(hpos, HSB, HSE, HLim)};
    paper_d = (hpos < PAPER_W) && (vpos < PAPER_H);
    line_d  = h_wrap;
    frame_d = h_wrap && v_wrap;
  end

  // Counter and flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcount_q <= '0;
      vcount_q <= '0;
      blank_q  <= 2'b00;
      sync_q   <= 2'b00;
      paper_q  <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      if (ce_i) begin
        blank_q <= blank_d;
        sync_q  <= sync_d;
        paper_q <= paper_d;
        line_q  <= line_d;
        frame_q <= frame_d;
      end
    end
  end

  assign hcount_o = hcount_q;
  assign vcount_o = vcount_q;
  assign blank_o  = blank_q;
  assign sync_o   = sync_q;
  assign paper_o  = paper_q;
  assign line_o   = line_q;
  assign frame_o  = frame_q;

`ifdef VIDEO_TIMING_IRQ_EN
  localparam int unsigned IcW = (INT_LEN > 0) ? $clog2(INT_LEN + 1) : 1;

  logic [IcW-1:0] irq_cnt_q, irq_cnt_d;
  logic           irq_n_q, irq_n_d;
  logic           irq_trig;

  assign irq_trig = (hpos == INT_H) && (vpos == INT_V) && (INT_LEN != 0);

  // Load on the trigger position (also when already running), then count down; /INT is
  // released on the ce that takes the counter to zero, giving INT_LEN ce of low.
  always_comb begin
    irq_cnt_d = irq_cnt_q;
    irq_n_d   = irq_n_q;
    if (ce_i) begin
      if (irq_trig) begin
        irq_cnt_d = IcW'(INT_LEN);
        irq_n_d   = 1'b0;
      end else if (irq_cnt_q != '0) begin
        irq_cnt_d = irq_cnt_q - 1'b1;
        if (irq_cnt_q == IcW'(1)) begin
          irq_n_d = 1'b1;
        end
      end
    end
  end

  // Interrupt counter and output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_cnt_q <= '0;
      irq_n_q   <= 1'b1;
    end else begin
      irq_cnt_q <= irq_cnt_d;
      irq_n_q   <= irq_n_d;
    end
  end

  assign irq_n_o = irq_n_q;
`else
  assign irq_n_o = 1'b1;
`endif

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
- Raster timing source for the +3 video path, on the producer side of the scandoubler interface.
- Generates pixel counters plus active-high blank[1:0] and sync[1:0] ({vertical, horizontal}) at 15 kHz line rate, qualified by a pixel clock enable.
- Also produces paper-area flag, line/frame strobes and the Z80 frame interrupt.
- Consumers (ULA fetch, scandoubler input side) sample all outputs on the same ce.

Parameters:
- HCW, 9, horizontal counter width
- VCW, 9, vertical counter width
- HTOTAL, 456, pixel clocks per line
- VTOTAL, 311, lines per frame
- PAPER_W, 256, paper width in pixels (from hcount 0)
- PAPER_H, 192, paper height in lines (from vcount 0)
- HBB / HBE, 320 / 416, hblank begin (inclusive) / end (exclusive)
- HSB / HSE, 344 / 376, hsync begin / end
- VBB / VBE, 248 / 256, vblank begin / end
- VSB / VSE, 248 / 252, vsync begin / end
- INT_V / INT_H, 248 / 0, interrupt start position
- INT_LEN, 64, interrupt length in pixel clocks (32 T-states)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ce  in  1  pixel clock enable; all state advances only when high
- hcount  out  HCW  current horizontal position
- vcount  out  VCW  current line
- blank  out  2  {vblank, hblank}, active high
- sync  out  2  {vsync, hsync}, active high
- paper  out  1  high inside paper window
- line  out  1  end-of-line strobe
- frame  out  1  end-of-frame strobe
- irq_n  out  1  Z80 /INT, active low

Behaviour:
- Reset (async assert, sync release): hcount=0, vcount=0, blank=00, sync=00, paper=0, line=0, frame=0, irq_n=1. Internal interrupt counter=0.
- Counters, per ce:
  - hcount==HTOTAL-1: hcount<=0, and vcount<=(vcount==VTOTAL-1)?0:vcount+1.
  - Otherwise hcount<=hcount+1 and vcount holds.
  - No update when ce=0.
- Window rule for each BEG/END pair: active when (BEG<END) ? (c>=BEG && c<END) : (c>=BEG || c<END).
  - BEG==END means never active.
  - BEG>END wraps through 0.
  - Horizontal pairs compare hcount; vertical pairs compare vcount.
- Registered outputs: blank, sync, paper, line and frame are registered on ce from the pre-increment counter values. They lag hcount/vcount by exactly one ce.
- paper = hcount<PAPER_W && vcount<PAPER_H.
- line = 1 for one ce interval after the ce where hcount wrapped. frame = 1 for one ce interval after the ce where both counters wrapped. Both stay high until the next ce; consumers AND them with ce.
- Vertical outputs change only in step with the counters (at the line boundary). No mid-line vsync shaping.
- Widths: comparisons are unsigned at HCW/VCW. Parameters must be < 2**HCW / 2**VCW and < HTOTAL / VTOTAL. Out-of-range values give never-active signals.
- Reset mid-frame: everything returns to reset values immediately. The first ce after release evaluates position (0,0) and sets paper=1 on that ce.

Optional Feature:
- Macro: VIDEO_TIMING_IRQ_EN.
- With the macro:
  - On the ce where (vcount==INT_V && hcount==INT_H), the interrupt counter loads INT_LEN and irq_n<=0.
  - Each later ce decrements the counter. irq_n<=1 on the ce where it reaches 0, giving exactly INT_LEN ce of low.
  - A retrigger while active reloads the counter.
- Without the macro: irq_n is tied to 1 and no counter logic is generated.

Test Plan:
- Reset, ce held high for 456 clocks -> hcount runs 0..455 then 0; vcount steps to 1; line=1 for exactly one ce interval following the wrap ce; frame stays 0.
- Run one full frame (456*311 ce) -> frame pulses once, vcount 310->0; blank[1] high for vcount 248..255 (delayed one ce); sync[1] high for 248..251.
- Line 100 -> hblank high for hcount samples 320..415, hsync high for 344..375 (each one ce late); paper high for 0..255; paper 0 on line 192.
- ce toggled 1-of-2 clocks -> same sequences as above with no state change on ce=0 clocks; line strobe spans two clocks.
- With VIDEO_TIMING_IRQ_EN: irq_n low for exactly 64 ce starting at (248,0) once per frame. Without the macro, irq_n stays 1 for a full frame.
- Assert reset at (150,200) mid-frame -> all outputs at reset values immediately while reset is low. After release: paper=1 after first ce, hcount=1.
